// File: rtl/adc_pkg.sv
// Shared types and defaults for the ADC conversion datapath.
package adc_pkg;

  localparam int ADC_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/cnt_core.sv
// Strobe-gated conversion counter with sync clear and terminal-count flag.
module cnt_core
  import adc_pkg::*;
#(
  parameter int WIDTH    = ADC_CNT_W,
  parameter int SATURATE = 1,
  parameter int MAX_CNT  = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_CNT);

  assign tc = (cnt == MAX_V);

  // At terminal count: hold in saturate mode, otherwise wrap to zero.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      if (!tc) begin
        cnt <= cnt + 1'b1;
      end else if (SATURATE == 0) begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/conv_counter.sv
// Conversion counter: FSM, result capture and valid/ready hand-off.
// state | meaning
// IDLE  | waiting for start, counter frozen
// COUNT | counting strobe-qualified cycles until stop/terminal count/abort
// HOLD  | result presented with res_valid until consumed or aborted
module conv_counter
  import adc_pkg::*;
#(
  parameter int WIDTH    = ADC_CNT_W,
  parameter int SATURATE = 1,
  parameter int MAX_CNT  = 2**WIDTH - 1
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             strb,
  input  logic             cnt_en,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             res_ovf,
  output logic             res_valid,
  input  logic             res_ready
);

  conv_state_t      state, state_nxt;
  logic             ovf, ovf_nxt;
  logic             valid_nxt;
  logic             clr, inc, tc, cap, cap_ovf;

  cnt_core #(
    .WIDTH    (WIDTH),
    .SATURATE (SATURATE),
    .MAX_CNT  (MAX_CNT)
  ) u_cnt_core (
    .clk   (clk),
    .rst_l (rst_l),
    .clr   (clr),
    .inc   (inc),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      ovf       <= 1'b0;
      result    <= '0;
      res_ovf   <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      ovf       <= ovf_nxt;
      res_valid <= valid_nxt;
      if (cap) begin
        result  <= cnt;
        res_ovf <= cap_ovf;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ovf_nxt   = ovf;
    valid_nxt = res_valid;
    clr       = 1'b0;
    inc       = 1'b0;
    cap       = 1'b0;
    cap_ovf   = ovf;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COUNT;
          clr       = 1'b1;
          ovf_nxt   = 1'b0;
        end
      end
      COUNT: begin
        if (abort) begin
          state_nxt = IDLE;
          clr       = 1'b1;
          ovf_nxt   = 1'b0;
        end else if (stop) begin
          // capture the pre-increment value; no count on the stop cycle
          state_nxt = HOLD;
          cap       = 1'b1;
          valid_nxt = 1'b1;
        end else if (start) begin
          clr       = 1'b1;
          ovf_nxt   = 1'b0;
        end else if (strb && cnt_en) begin
          inc = 1'b1;
          if (tc && (SATURATE != 0)) begin
            state_nxt = HOLD;
            cap       = 1'b1;
            cap_ovf   = 1'b1;
            valid_nxt = 1'b1;
          end else if (tc) begin
            ovf_nxt = 1'b1;
          end
        end
      end
      HOLD: begin
        if (abort) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end else if (res_ready) begin
          valid_nxt = 1'b0;
          if (start) begin
            state_nxt = COUNT;
            clr       = 1'b1;
            ovf_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == COUNT);

endmodule
